// File: rtl/instr_fetch.sv
// Instruction-fetch controller: latches the PC into the memory address
// register, waits MEM_LAT cycles for the synchronous memory, captures the
// word into IrOut and pulses IrValid/IncrPc for one cycle.
//
// Optional feature macro: INSTR_FETCH_PREFETCH_EN
//   When defined, each completed fetch is followed by a speculative read of
//   the next sequential address into a one-entry prefetch buffer, so a
//   Start at PcValue == PfAddr completes one cycle later. Flush discards it.
//   When undefined, Flush is ignored and there is no PWAIT state.
//
// Handshake: Start is a level request sampled only while Busy=0. Once
// accepted, exactly one IrValid/IncrPc pulse follows unless Clear aborts it.
module instr_fetch #(
    parameter int n       = 16,
    parameter int MEM_LAT = 1
) (
    input  logic         Clock,
    input  logic         Clear,
    input  logic         Start,
    input  logic         Flush,
    input  logic [n-1:0] PcValue,
    input  logic [n-1:0] MemData,
    output logic [n-1:0] MemAddr,
    output logic         MemRd,
    output logic [n-1:0] IrOut,
    output logic         IrValid,
    output logic         IncrPc,
    output logic         Busy
);

`ifdef INSTR_FETCH_PREFETCH_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_PWAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
`endif

    // Latency counter is 3 bits because MEM_LAT is limited to 1..7.
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t       state_q;
    logic [2:0]   cnt_q;
    logic [n-1:0] mem_addr_q;
    logic         mem_rd_q;
    logic [n-1:0] ir_q;

`ifdef INSTR_FETCH_PREFETCH_EN
    logic         pf_valid_q;
    logic [n-1:0] pf_addr_q;
    logic [n-1:0] pf_data_q;
`else
    logic         unused_flush;
    assign unused_flush = Flush;
`endif

    // Fetch FSM: all outputs except the DONE-decoded pulses are registers.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            ir_q       <= '0;
`ifdef INSTR_FETCH_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_addr_q  <= '0;
            pf_data_q  <= '0;
`endif
        end else begin
`ifdef INSTR_FETCH_PREFETCH_EN
            // A PC overwrite makes any buffered next word stale.
            if (Flush) pf_valid_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    mem_rd_q <= 1'b0;
                    if (Start) begin
`ifdef INSTR_FETCH_PREFETCH_EN
                        if (pf_valid_q && !Flush && (PcValue == pf_addr_q)) begin
                            // Prefetch hit: no memory access needed.
                            ir_q       <= pf_data_q;
                            pf_valid_q <= 1'b0;
                            state_q    <= S_DONE;
                        end else begin
                            pf_valid_q <= 1'b0;
                            mem_addr_q <= PcValue;
                            mem_rd_q   <= 1'b1;
                            cnt_q      <= LAT_INIT;
                            state_q    <= S_WAIT;
                        end
`else
                        mem_addr_q <= PcValue;
                        mem_rd_q   <= 1'b1;
                        cnt_q      <= LAT_INIT;
                        state_q    <= S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
                    // MemAddr is held here, so later PcValue changes are harmless.
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        ir_q     <= MemData;
                        mem_rd_q <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef INSTR_FETCH_PREFETCH_EN
                    // Speculatively read the next sequential word (wraps mod 2^n).
                    mem_addr_q <= mem_addr_q + n'(1);
                    mem_rd_q   <= 1'b1;
                    cnt_q      <= LAT_INIT;
                    state_q    <= S_PWAIT;
`else
                    state_q <= S_IDLE;
`endif
                end
`ifdef INSTR_FETCH_PREFETCH_EN
                S_PWAIT: begin
                    if (Flush) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        pf_data_q  <= MemData;
                        pf_addr_q  <= mem_addr_q;
                        pf_valid_q <= 1'b1;
                        mem_rd_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MemAddr = mem_addr_q;
    assign MemRd   = mem_rd_q;
    assign IrOut   = ir_q;
    assign IrValid = (state_q == S_DONE);
    assign IncrPc  = (state_q == S_DONE);
    assign Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one MEM_LAT=1 instance (main checks) and
// one MEM_LAT=3 instance sharing the same stimulus for latency checks.
module tb_instr_fetch;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [15:0] pc_drv = 16'h0000;
    logic [15:0] pc_cnt = 16'h0000;
    logic        pc_mode = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_value;

    logic [15:0] mem_addr1, mem_data1, ir_out1;
    logic        mem_rd1, ir_valid1, incr1, busy1;
    logic [15:0] mem_addr3, mem_data3, ir_out3;
    logic        mem_rd3, ir_valid3, incr3, busy3;

    int checks = 0;
    int failures = 0;
    int incr_cnt = 0;
    int valid_cnt = 0;
    logic [15:0] exp_q[$];

    // Clock and reset block
    always #5 Clock = ~Clock;

    // Memory contents: 0x0010 holds 0xA5A5, every other word is addr ^ 0xC3C3.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'hC3C3);
    endfunction

    assign mem_data1 = mem_f(mem_addr1);
    assign mem_data3 = mem_f(mem_addr3);
    assign pc_value  = pc_mode ? pc_cnt : pc_drv;

    // PC counter register model, advanced by IncrPc.
    always @(posedge Clock) begin
        if (pc_load) pc_cnt <= 16'h0010;
        else if (incr1) pc_cnt <= pc_cnt + 16'd1;
    end

    // Pulse counters for the MEM_LAT=1 instance.
    always @(posedge Clock) begin
        if (incr1 === 1'b1) incr_cnt++;
        if (ir_valid1 === 1'b1) valid_cnt++;
    end

    instr_fetch #(.n(16), .MEM_LAT(1)) u_lat1 (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Flush(Flush),
        .PcValue(pc_value), .MemData(mem_data1), .MemAddr(mem_addr1),
        .MemRd(mem_rd1), .IrOut(ir_out1), .IrValid(ir_valid1),
        .IncrPc(incr1), .Busy(busy1)
    );

    instr_fetch #(.n(16), .MEM_LAT(3)) u_lat3 (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Flush(Flush),
        .PcValue(pc_value), .MemData(mem_data3), .MemAddr(mem_addr3),
        .MemRd(mem_rd3), .IrOut(ir_out3), .IrValid(ir_valid3),
        .IncrPc(incr3), .Busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 12 && busy1 !== 1'b0; i++) step();
        check(tag, busy1, 1'b0);
    endtask

    initial begin
        int got;
        int incr_base;
        int valid_base;

        // Reset state
        Clear = 1'b1;
        step();
        step();
        check("rst_memaddr", mem_addr1, 16'h0000);
        check("rst_memrd", mem_rd1, 1'b0);
        check("rst_irout", ir_out1, 16'h0000);
        check("rst_irvalid", ir_valid1, 1'b0);
        check("rst_incrpc", incr1, 1'b0);
        check("rst_busy", busy1, 1'b0);

        // Basic fetch of 0x0010, MEM_LAT=1 and MEM_LAT=3 side by side
        incr_base = incr_cnt;
        Clear = 1'b0;
        Start = 1'b1;
        pc_drv = 16'h0010;
        step(); // edge 0
        Start = 1'b0;
        check("e0_memaddr", mem_addr1, 16'h0010);
        check("e0_memrd", mem_rd1, 1'b1);
        check("e0_busy", busy1, 1'b1);
        check("e0_irvalid", ir_valid1, 1'b0);
        check("l3_e0_memaddr", mem_addr3, 16'h0010);
        step(); // edge 1
        check("e1_irvalid", ir_valid1, 1'b0);
        check("e1_memaddr", mem_addr1, 16'h0010);
        check("l3_e1_irvalid", ir_valid3, 1'b0);
        step(); // edge 2
        check("e2_irout", ir_out1, 16'hA5A5);
        check("e2_irvalid", ir_valid1, 1'b1);
        check("e2_incrpc", incr1, 1'b1);
        check("e2_memrd", mem_rd1, 1'b0);
        check("l3_e2_irvalid", ir_valid3, 1'b0);
        check("l3_e2_memaddr", mem_addr3, 16'h0010);
        step(); // edge 3
        check("e3_irvalid", ir_valid1, 1'b0);
        check("e3_incrpc", incr1, 1'b0);
`ifdef INSTR_FETCH_PREFETCH_EN
        check("e3_busy_pwait", busy1, 1'b1);
        check("e3_pf_addr", mem_addr1, 16'h0011);
`else
        check("e3_busy", busy1, 1'b0);
`endif
        check("one_incr", incr_cnt - incr_base, 1);
        check("l3_e3_irvalid", ir_valid3, 1'b0);
        check("l3_e3_memaddr", mem_addr3, 16'h0010);
        check("l3_e3_memrd", mem_rd3, 1'b1);
        step(); // edge 4
        check("l3_e4_irvalid", ir_valid3, 1'b1);
        check("l3_e4_incrpc", incr3, 1'b1);
        check("l3_e4_irout", ir_out3, 16'hA5A5);
        wait_idle("idle_after_basic");

        // Start held high with the PC counter connected
        Clear = 1'b1;
        pc_load = 1'b1;
        pc_mode = 1'b1;
        step();
        Clear = 1'b0;
        pc_load = 1'b0;
        incr_base = incr_cnt;
        valid_base = valid_cnt;
        exp_q.push_back(16'hA5A5);
        exp_q.push_back(16'hC3D2);
        exp_q.push_back(16'hC3D1);
        Start = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 3; c++) begin
            step();
            if (ir_valid1 === 1'b1) begin
                check("cont_irout", ir_out1, exp_q.pop_front());
                got++;
                if (got == 3) Start = 1'b0;
            end
        end
        check("cont_fetches", got, 3);
        step();
        step();
        check("cont_incr_pulses", incr_cnt - incr_base, 3);
        check("cont_valid_pulses", valid_cnt - valid_base, 3);
        check("cont_pc", pc_cnt, 16'h0013);
        pc_mode = 1'b0;
        wait_idle("idle_after_cont");

        // Clear mid-WAIT aborts without a pulse, then a normal fetch
        incr_base = incr_cnt;
        valid_base = valid_cnt;
        pc_drv = 16'h0020;
        Start = 1'b1;
        step(); // edge 0
        Start = 1'b0;
        Clear = 1'b1;
        step(); // edge 1
        check("clr_memaddr", mem_addr1, 16'h0000);
        check("clr_memrd", mem_rd1, 1'b0);
        check("clr_irout", ir_out1, 16'h0000);
        check("clr_busy", busy1, 1'b0);
        check("clr_irvalid", ir_valid1, 1'b0);
        Clear = 1'b0;
        step();
        step();
        step();
        check("clr_no_incr", incr_cnt - incr_base, 0);
        check("clr_no_valid", valid_cnt - valid_base, 0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        check("post_clr_irout", ir_out1, 16'hC3E3);
        check("post_clr_irvalid", ir_valid1, 1'b1);
        step();
        wait_idle("idle_after_clr");

        // PcValue changes while in WAIT: the fetch uses the accepted address
        pc_drv = 16'h0010;
        Start = 1'b1;
        step(); // edge 0
        Start = 1'b0;
        pc_drv = 16'h0200;
        step(); // edge 1
        check("pcchg_memaddr", mem_addr1, 16'h0010);
        step(); // edge 2
        check("pcchg_irout", ir_out1, 16'hA5A5);
        check("pcchg_irvalid", ir_valid1, 1'b1);
        step();
        wait_idle("idle_after_pcchg");

`ifdef INSTR_FETCH_PREFETCH_EN
        // Prefetch hit, then Flush during PWAIT
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        pc_drv = 16'h0010;
        Start = 1'b1;
        step(); // edge 0
        Start = 1'b0;
        step(); // edge 1
        step(); // edge 2: DONE
        step(); // edge 3: PWAIT on 0x0011
        check("pf_memaddr", mem_addr1, 16'h0011);
        check("pf_memrd", mem_rd1, 1'b1);
        check("pf_busy", busy1, 1'b1);
        step(); // edge 4
        step(); // edge 5: buffered, back to IDLE
        check("pf_done_busy", busy1, 1'b0);
        pc_drv = 16'h0011;
        Start = 1'b1;
        step(); // edge 6: hit goes straight to DONE
        Start = 1'b0;
        check("pf_hit_irvalid", ir_valid1, 1'b1);
        check("pf_hit_irout", ir_out1, 16'hC3D2);
        step(); // edge 7: PWAIT on 0x0012
        check("pf2_busy", busy1, 1'b1);
        Flush = 1'b1;
        step(); // edge 8
        Flush = 1'b0;
        check("flush_busy", busy1, 1'b0);
        check("flush_memrd", mem_rd1, 1'b0);
        pc_drv = 16'h0012;
        Start = 1'b1;
        step(); // edge 9
        Start = 1'b0;
        check("flush_miss_irvalid0", ir_valid1, 1'b0);
        step(); // edge 10
        check("flush_miss_irvalid1", ir_valid1, 1'b0);
        step(); // edge 11
        check("flush_miss_irvalid2", ir_valid1, 1'b1);
        check("flush_miss_irout", ir_out1, 16'hC3D1);
        step();
        wait_idle("idle_after_pf");
`else
        // Flush has no effect without prefetch
        pc_drv = 16'h0030;
        Start = 1'b1;
        Flush = 1'b1;
        step(); // edge 0
        Start = 1'b0;
        step(); // edge 1
        check("noflush_busy", busy1, 1'b1);
        step(); // edge 2
        Flush = 1'b0;
        check("noflush_irvalid", ir_valid1, 1'b1);
        check("noflush_irout", ir_out1, 16'hC3F3);
        step();
        wait_idle("idle_after_noflush");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
